cpu_run_ctrl: RTL

- Single-clock run/step controller for the board-level computer.
- Replaces the divided-clock mux with a clock-enable scheme: the CPU runs on CLK and advances only when cpu_ce is high.
- Provides selectable run rates, debounced single-step and run/stop buttons, an address breakpoint, and a sequenced CPU reset.
- Sits between the board inputs and comp; its counters feed the display mux.

---
 rtl/cpu_run_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Single-clock run/step controller for the board-level computer. The CPU is
// clocked by CLK and advances only on cycles where cpu_ce is high.
// Provides:
//   - selectable run rates, using a clock-enable prescaler
//   - debounced single-step and run/stop buttons
//   - an address breakpoint
//   - a sequenced CPU reset
//
// Ports:
//   CLK        system clock
//   RESET      asynchronous active-low reset
//   rate_sel   0..11 -> 1,10,100,1k,10k,100k,1M,10M,20M,25M,50M,100M Hz;
//              12..15 -> step mode
//   btn_step   raw step button (async, active-high)
//   btn_run    raw run/stop toggle button (async, active-high)
//   bp_en      breakpoint enable
//   bp_addr    breakpoint address
//   addr       current CPU address bus
//   cpu_ce     one-CLK-wide CPU advance enable (registered)
//   cpu_reset  active-high synchronous CPU reset (registered)
//   state      0=RST_HOLD 1=RUN 2=HALT 3=STEP
//   bp_hit     sticky breakpoint-hit flag
//   cycle_cnt  number of cpu_ce pulses issued (wraps)
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
   parameter int unsigned CLK_HZ     = 100000000,
   parameter int unsigned DEB_CYCLES = 1000000,
   parameter int unsigned RST_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [3:0]  rate_sel,
   input  logic        btn_step,
   input  logic        btn_run,
   input  logic        bp_en,
   input  logic [31:0] bp_addr,
   input  logic [31:0] addr,
   output logic        cpu_ce,
   output logic        cpu_reset,
   output logic [1:0]  state,
   output logic        bp_hit,
   output logic [31:0] cycle_cnt
);

   localparam int DCW = $clog2(DEB_CYCLES + 1);
   localparam int RCW = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_RST_HOLD = 2'd0,
      ST_RUN      = 2'd1,
      ST_HALT     = 2'd2,
      ST_STEP     = 2'd3
   } state_e;

   // Divisor per rate code, folded at elaboration. Codes 12..15 (step mode)
   // and rates faster than CLK both clamp to 1.
   function automatic logic [15:0][31:0] build_div_tbl();
      logic [15:0][31:0] t;
      int unsigned       f;
      for (int i = 0; i < 16; i++) begin
         case (i)
            0:       f = 1;
            1:       f = 10;
            2:       f = 100;
            3:       f = 1000;
            4:       f = 10000;
            5:       f = 100000;
            6:       f = 1000000;
            7:       f = 10000000;
            8:       f = 20000000;
            9:       f = 25000000;
            10:      f = 50000000;
            11:      f = 100000000;
            default: f = 0;
         endcase
         if (f == 0 || CLK_HZ < f) t[i] = 32'd1;
         else                      t[i] = 32'(CLK_HZ / f);
      end
      return t;
   endfunction

   localparam logic [15:0][31:0] DIV_TBL = build_div_tbl();

   // ---------------------------------------------------------------- buttons
   // Bit 0 = step, bit 1 = run.
   logic [1:0]          btn_raw;
   logic [1:0]          sync1_q, sync2_q, lvl_q, deb_q, deb_dly_q;
   logic [1:0][DCW-1:0] dcnt_q;
   logic                step_press, run_press;

   assign btn_raw = {btn_run, btn_step};

   // lvl_q tracks the synced level. Any change restarts the stability counter.
   // deb_q takes the level once it has been stable for DEB_CYCLES cycles.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         lvl_q     <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         dcnt_q    <= '0;
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         deb_dly_q <= deb_q;
         for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != lvl_q[b]) begin
               lvl_q[b]  <= sync2_q[b];
               dcnt_q[b] <= '0;
            end else if (dcnt_q[b] == DCW'(DEB_CYCLES - 1)) begin
               deb_q[b] <= lvl_q[b];
            end else begin
               dcnt_q[b] <= dcnt_q[b] + DCW'(1);
            end
         end
      end
   end

   assign step_press = deb_q[0] & ~deb_dly_q[0];
   assign run_press  = deb_q[1] & ~deb_dly_q[1];

   // -------------------------------------------------------------- prescaler
   state_e      state_q, state_d;
   logic [3:0]  rate_q;
   logic [31:0] presc_q, presc_d;
   logic [31:0] div;
   logic        rate_chg, rate_run, tick;

   assign div      = DIV_TBL[rate_sel];
   assign rate_run = (rate_sel < 4'd12);
   assign rate_chg = (rate_sel != rate_q);
   // A rate change restarts the count, so no stale tick is taken that cycle.
   assign tick     = (state_q == ST_RUN) && !rate_chg && (presc_q == div - 32'd1);

   always_comb begin
      presc_d = presc_q + 32'd1;
      if (state_q != ST_RUN || rate_chg || tick) presc_d = '0;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rate_q  <= '0;
         presc_q <= '0;
      end else begin
         rate_q  <= rate_sel;
         presc_q <= presc_d;
      end
   end

   // -------------------------------------------------------------------- FSM
   logic           cpu_ce_q, cpu_ce_d;
   logic           cpu_reset_q, cpu_reset_d;
   logic           bp_hit_q, bp_hit_d;
   logic           guard_q, guard_d;
   logic [31:0]    cycle_cnt_q, cycle_cnt_d;
   logic [RCW-1:0] rst_cnt_q, rst_cnt_d;

   always_comb begin
      state_d     = state_q;
      cpu_ce_d    = 1'b0;
      cpu_reset_d = 1'b0;
      bp_hit_d    = bp_hit_q;
      guard_d     = guard_q;
      cycle_cnt_d = cycle_cnt_q;
      rst_cnt_d   = rst_cnt_q;
      case (state_q)
         ST_RST_HOLD: begin
            cpu_reset_d = 1'b1;
            if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
               cpu_reset_d = 1'b0;
               state_d     = rate_run ? ST_RUN : ST_HALT;
            end else begin
               rst_cnt_d = rst_cnt_q + RCW'(1);
            end
         end
         ST_RUN: begin
            // Leaving RUN beats a coincident tick: no enable on the exit cycle.
            if (run_press || !rate_run) begin
               state_d = ST_HALT;
            end else if (tick) begin
               if (bp_en && addr == bp_addr && !guard_q) begin
                  bp_hit_d = 1'b1;
                  state_d  = ST_HALT;
               end else begin
                  cpu_ce_d    = 1'b1;
                  cycle_cnt_d = cycle_cnt_q + 32'd1;
                  guard_d     = 1'b0;
               end
            end
         end
         ST_HALT: begin
            // Run wins over a simultaneous step. In step mode run is ignored.
            if (run_press && rate_run) begin
               state_d  = ST_RUN;
               guard_d  = 1'b1;
               bp_hit_d = 1'b0;
            end else if (step_press) begin
               // The enable is issued as STEP is entered, so it is high
               // during the single STEP cycle and never while in HALT.
               state_d     = ST_STEP;
               cpu_ce_d    = 1'b1;
               cycle_cnt_d = cycle_cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= ST_RST_HOLD;
         cpu_ce_q    <= 1'b0;
         cpu_reset_q <= 1'b1;
         bp_hit_q    <= 1'b0;
         guard_q     <= 1'b0;
         cycle_cnt_q <= '0;
         rst_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cpu_ce_q    <= cpu_ce_d;
         cpu_reset_q <= cpu_reset_d;
         bp_hit_q    <= bp_hit_d;
         guard_q     <= guard_d;
         cycle_cnt_q <= cycle_cnt_d;
         rst_cnt_q   <= rst_cnt_d;
      end
   end

   assign cpu_ce    = cpu_ce_q;
   assign cpu_reset = cpu_reset_q;
   assign state     = state_q;
   assign bp_hit    = bp_hit_q;
   assign cycle_cnt = cycle_cnt_q;

endmodule
